instr_mem_avalon: RTL and testbench

- Parametrised, multi-region read-only instruction memory for CPU testbenches.
- Presents an Avalon-MM read slave with `waitrequest` and a configurable number of wait states.
- Maps up to NUM_REGIONS disjoint byte-address windows (reset vector, low memory, far-branch and far-jump targets) onto one word array.
- Flags unmapped or misaligned fetches.

---
 rtl/instr_mem_avalon.sv | 102 ++++++++++
 tb/tb_instr_mem_avalon.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_avalon.sv
// Read-only multi-region instruction memory behind an Avalon-MM read slave.
// Byte-address windows map onto one word array; unmapped/misaligned fetches are flagged.
module instr_mem_avalon #(
  parameter string                           INIT_FILE     = "",
  parameter int unsigned                     DEPTH         = 1024,
  parameter int unsigned                     NUM_REGIONS   = 4,
  parameter logic [32*NUM_REGIONS-1:0]       REGION_BASE   = {32'hC0000000, 32'hBFC1FFFC, 32'h00000000, 32'hBFC00000},
  parameter logic [32*NUM_REGIONS-1:0]       REGION_WORDS  = {32'd64, 32'd64, 32'd128, 32'd512},
  parameter logic [32*NUM_REGIONS-1:0]       REGION_OFFSET = {32'd704, 32'd640, 32'd512, 32'd0},
  parameter int unsigned                     WAIT_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        addr_fault
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic [3:0]  lat_be;

  logic [31:0] mem [DEPTH];

  // ROM image: zero fill.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  logic        hit;
  logic [31:0] idx;
  logic [31:0] diff;
  logic        fault;
  logic [31:0] word;
  logic [31:0] masked;

  // Window test is on the unsigned difference, so windows may wrap past 2^32.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    diff = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      diff = lat_addr - REGION_BASE[32*i +: 32];
      if (!hit && ({2'b00, diff} < {REGION_WORDS[32*i +: 32], 2'b00})) begin
        hit = 1'b1;
        idx = REGION_OFFSET[32*i +: 32] + {2'b00, diff[31:2]};
      end
    end
  end

  always_comb begin
    fault  = (lat_addr[1:0] != 2'b00) || !hit || (idx >= DEPTH);
    word   = mem[idx[AW-1:0]];
    masked = word & {{8{lat_be[3]}}, {8{lat_be[2]}}, {8{lat_be[1]}}, {8{lat_be[0]}}};
  end

  assign waitrequest = read && (state != RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_be     <= '0;
      readdata   <= '0;
      addr_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read) begin
            lat_addr <= address;
            lat_be   <= byteenable;
            cnt      <= 4'(WAIT_CYCLES);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!read) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            readdata   <= fault ? '0 : masked;
            addr_fault <= fault;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_avalon.sv
// Directed self-checking bench for instr_mem_avalon: three instances with 1, 0 and 4 wait states.
module tb_instr_mem_avalon;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        rd;
  logic [3:0]  byteenable;
  logic [1:0]  sel;

  logic        read0, read1, read4;
  logic        wr0, wr1, wr4;
  logic [31:0] rdata0, rdata1, rdata4;
  logic        flt0, flt1, flt4;
  logic        wr_s;
  logic [31:0] rdata_s;
  logic        flt_s;

  int checks   = 0;
  int failures = 0;
  int edges;

  always #5 clk = ~clk;

  assign read0 = rd && (sel == 2'd0);
  assign read1 = rd && (sel == 2'd1);
  assign read4 = rd && (sel == 2'd2);
  assign wr_s    = (sel == 2'd0) ? wr0    : (sel == 2'd1) ? wr1    : wr4;
  assign rdata_s = (sel == 2'd0) ? rdata0 : (sel == 2'd1) ? rdata1 : rdata4;
  assign flt_s   = (sel == 2'd0) ? flt0   : (sel == 2'd1) ? flt1   : flt4;

  instr_mem_avalon #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .read(read1), .byteenable(byteenable),
    .waitrequest(wr1), .readdata(rdata1), .addr_fault(flt1));

  instr_mem_avalon #(
    .WAIT_CYCLES(0),
    .REGION_OFFSET({32'd704, 32'd640, 32'd512, 32'd1000})
  ) dut0 (
    .clk(clk), .reset(reset), .address(address), .read(read0), .byteenable(byteenable),
    .waitrequest(wr0), .readdata(rdata0), .addr_fault(flt0));

  instr_mem_avalon #(
    .WAIT_CYCLES(4),
    .REGION_BASE({32'hFFFFFFFC, 32'hBFC1FFFC, 32'h00000000, 32'hBFC00000})
  ) dut4 (
    .clk(clk), .reset(reset), .address(address), .read(read4), .byteenable(byteenable),
    .waitrequest(wr4), .readdata(rdata4), .addr_fault(flt4));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one read, count rising edges until waitrequest drops, then hold read
  // through the accept edge and confirm the next request is stalled again.
  task automatic do_read(input logic [31:0] a, input logic [3:0] be, output int n);
    @(negedge clk);
    address = a; byteenable = be; rd = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (wr_s && n < 40);
    @(posedge clk); #1;
    check_eq("b2b_wait", 32'(wr_s), 32'd1);
    rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd = 1'b0; address = '0; byteenable = 4'hF; sel = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    dut1.mem[0]    = 32'h3C021234;
    dut1.mem[513]  = 32'h24420001;
    dut1.mem[640]  = 32'hDEADBEEF;
    dut1.mem[706]  = 32'h08000010;
    dut0.mem[1000] = 32'h0BADF00D;
    dut0.mem[1023] = 32'h7777AAAA;
    dut4.mem[512]  = 32'h11112222;
    dut4.mem[704]  = 32'hA5A5F00D;
    check_eq("rst_rdata", rdata_s, 32'h0);
    check_eq("rst_fault", 32'(flt_s), 32'd0);
    check_eq("rst_wr_idle", 32'(wr_s), 32'd0);
    rd = 1'b1; #1;
    check_eq("rst_wr_read", 32'(wr_s), 32'd1);
    rd = 1'b0;
    @(negedge clk); reset = 1'b0;

    do_read(32'hBFC00000, 4'hF, edges);
    check_eq("rv_latency", edges, 32'd3);
    check_eq("rv_data", rdata_s, 32'h3C021234);
    check_eq("rv_fault", 32'(flt_s), 32'd0);

    do_read(32'hC0000008, 4'hF, edges);
    check_eq("r3_data", rdata_s, 32'h08000010);
    do_read(32'h00000004, 4'hF, edges);
    check_eq("r1_data", rdata_s, 32'h24420001);
    do_read(32'hBFC1FFFC, 4'hF, edges);
    check_eq("r2_data", rdata_s, 32'hDEADBEEF);

    // Abort: drop read while in WAIT.
    @(negedge clk); address = 32'hBFC00000; rd = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_wr_wait", 32'(wr_s), 32'd1);
    @(negedge clk); rd = 1'b0; #1;
    check_eq("abort_wr_low", 32'(wr_s), 32'd0);
    @(posedge clk); #1;
    check_eq("abort_rdata", rdata_s, 32'hDEADBEEF);
    check_eq("abort_fault", 32'(flt_s), 32'd0);
    do_read(32'hBFC00000, 4'hF, edges);
    check_eq("post_abort_latency", edges, 32'd3);

    // Address/byteenable changes during WAIT are ignored.
    @(negedge clk); address = 32'hC0000008; byteenable = 4'hF; rd = 1'b1;
    @(posedge clk); #1;
    address = 32'hBFC00000; byteenable = 4'h0;
    edges = 1;
    while (wr_s && edges < 40) begin @(posedge clk); #1; edges++; end
    check_eq("latch_latency", edges, 32'd3);
    check_eq("latch_data", rdata_s, 32'h08000010);
    @(posedge clk); #1; rd = 1'b0;

    // Reset during WAIT with read held high.
    @(negedge clk); address = 32'hBFC1FFFC; byteenable = 4'hF; rd = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_eq("rstw_rdata", rdata_s, 32'h0);
    check_eq("rstw_fault", 32'(flt_s), 32'd0);
    check_eq("rstw_wr", 32'(wr_s), 32'd1);
    @(negedge clk); reset = 1'b0;
    edges = 0;
    do begin @(posedge clk); #1; edges++; end while (wr_s && edges < 40);
    check_eq("rstw_latency", edges, 32'd3);
    check_eq("rstw_data", rdata_s, 32'hDEADBEEF);
    @(posedge clk); #1; rd = 1'b0;

    do_read(32'h10000000, 4'hF, edges);
    check_eq("unmapped_data", rdata_s, 32'h0);
    check_eq("unmapped_fault", 32'(flt_s), 32'd1);
    do_read(32'hBFC00002, 4'hF, edges);
    check_eq("misalign_data", rdata_s, 32'h0);
    check_eq("misalign_fault", 32'(flt_s), 32'd1);
    do_read(32'hBFC00000, 4'hF, edges);
    check_eq("clear_fault", 32'(flt_s), 32'd0);
    check_eq("clear_data", rdata_s, 32'h3C021234);

    do_read(32'hBFC00000, 4'b0011, edges);
    check_eq("be0011_data", rdata_s, 32'h00001234);
    do_read(32'hBFC00000, 4'b1010, edges);
    check_eq("be1010_data", rdata_s, 32'h3C001200);
    do_read(32'hBFC00000, 4'b0000, edges);
    check_eq("be0000_data", rdata_s, 32'h0);
    check_eq("be0000_fault", 32'(flt_s), 32'd0);

    // Zero wait states, region 0 relocated near the top of the array.
    sel = 2'd0;
    do_read(32'hBFC00000, 4'hF, edges);
    check_eq("w0_latency", edges, 32'd2);
    check_eq("w0_data", rdata_s, 32'h0BADF00D);
    do_read(32'hBFC0005C, 4'hF, edges);
    check_eq("w0_last_word", rdata_s, 32'h7777AAAA);
    check_eq("w0_last_fault", 32'(flt_s), 32'd0);
    do_read(32'hBFC00060, 4'hF, edges);
    check_eq("w0_oob_data", rdata_s, 32'h0);
    check_eq("w0_oob_fault", 32'(flt_s), 32'd1);

    // Four wait states, a window based at 0xFFFFFFFC that wraps through zero.
    sel = 2'd2;
    do_read(32'hFFFFFFFC, 4'hF, edges);
    check_eq("w4_latency", edges, 32'd6);
    check_eq("w4_wrap_data", rdata_s, 32'hA5A5F00D);
    do_read(32'h00000000, 4'hF, edges);
    check_eq("w4_priority", rdata_s, 32'h11112222);
    check_eq("w4_fault", 32'(flt_s), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
